// File: rtl/user_obi_mgr_arb.sv
// Round-robin OBI manager arbiter: N upstream requesters onto one downstream
// port, with an ID FIFO that steers in-order responses back to their origin.
module user_obi_mgr_arb #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MaxTrans  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*DataWidth/8-1:0] be_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [NumReq*DataWidth-1:0]   rdata_o,
    output logic [NumReq-1:0]             err_o,
    output logic                          mgr_req_o,
    output logic [AddrWidth-1:0]          mgr_addr_o,
    output logic                          mgr_we_o,
    output logic [DataWidth/8-1:0]        mgr_be_o,
    output logic [DataWidth-1:0]          mgr_wdata_o,
    input  logic                          mgr_gnt_i,
    input  logic                          mgr_rvalid_i,
    input  logic [DataWidth-1:0]          mgr_rdata_i,
    input  logic                          mgr_err_i
);

    localparam int IdxW = $clog2(NumReq);
    localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int CntW = $clog2(MaxTrans + 1);
    localparam int BeW  = DataWidth / 8;

    logic [IdxW-1:0] ptr_q;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] rr_sel;
    logic [IdxW-1:0] sel;
    logic            full;
    logic            push;
    logic            pop;
    logic [IdxW-1:0] head;
    logic [IdxW-1:0] fifo_q [MaxTrans];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] cnt_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after the priority pointer, wrapping.
    always_comb begin
        int              sum;
        logic            found;
        logic [IdxW-1:0] cand;
        rr_sel = '0;
        found  = 1'b0;
        sum    = 0;
        cand   = '0;
        for (int i = 0; i < NumReq; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= NumReq) sum = sum - NumReq;
            cand = IdxW'(sum);
            if (!found && req_i[cand]) begin
                rr_sel = cand;
                found  = 1'b1;
            end
        end
    end

    // A dropped locked request falls back to round-robin selection.
    assign sel       = (lock_q && req_i[lock_idx_q]) ? lock_idx_q : rr_sel;
    assign full      = (cnt_q == CntW'(MaxTrans));
    assign mgr_req_o = rst_ni & (|req_i) & ~full;
    assign push      = mgr_req_o & mgr_gnt_i;
    assign pop       = mgr_rvalid_i & (cnt_q != '0);
    assign head      = fifo_q[rptr_q];

    always_comb begin
        mgr_addr_o  = '0;
        mgr_we_o    = 1'b0;
        mgr_be_o    = '0;
        mgr_wdata_o = '0;
        gnt_o       = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (mgr_req_o && sel == IdxW'(i)) begin
                mgr_addr_o  = addr_i[i*AddrWidth +: AddrWidth];
                mgr_we_o    = we_i[i];
                mgr_be_o    = be_i[i*BeW +: BeW];
                mgr_wdata_o = wdata_i[i*DataWidth +: DataWidth];
                gnt_o[i]    = mgr_gnt_i;
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (pop && head == IdxW'(i)) begin
                rvalid_o[i]                        = 1'b1;
                rdata_o[i*DataWidth +: DataWidth]  = mgr_rdata_i;
                err_o[i]                           = mgr_err_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= mgr_req_o & ~mgr_gnt_i;
            lock_idx_q <= sel;
            if (push) begin
                ptr_q <= (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // ID storage carries no control meaning, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= sel;
    end

endmodule

// File: tb/tb_user_obi_mgr_arb.sv
// Directed bench for user_obi_mgr_arb; responses are checked by a
// scoreboard queue filled by stimulus and drained by a monitor.
module tb_user_obi_mgr_arb;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MT = 2;
    localparam logic [31:0] K = 32'h5A5A_0000;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]      req;
    logic [NR*AW-1:0]   addr;
    logic [NR-1:0]      we;
    logic [NR*DW/8-1:0] be;
    logic [NR*DW-1:0]   wdata;
    logic [NR-1:0]      gnt;
    logic [NR-1:0]      rvalid;
    logic [NR*DW-1:0]   rdata;
    logic [NR-1:0]      err;
    logic               mgr_req;
    logic [AW-1:0]      mgr_addr;
    logic               mgr_we;
    logic [DW/8-1:0]    mgr_be;
    logic [DW-1:0]      mgr_wdata;
    logic               mgr_gnt;
    logic               mgr_rvalid;
    logic [DW-1:0]      mgr_rdata;
    logic               mgr_err;

    logic          man_v;
    logic [DW-1:0] man_d;
    logic          man_e;
    logic          auto_en;
    logic          auto_v;
    logic [DW-1:0] auto_d;

    assign mgr_rvalid = man_v | auto_v;
    assign mgr_rdata  = auto_v ? auto_d : man_d;
    assign mgr_err    = auto_v ? 1'b0 : man_e;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    user_obi_mgr_arb #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .mgr_req_o(mgr_req), .mgr_addr_o(mgr_addr), .mgr_we_o(mgr_we),
        .mgr_be_o(mgr_be), .mgr_wdata_o(mgr_wdata),
        .mgr_gnt_i(mgr_gnt), .mgr_rvalid_i(mgr_rvalid),
        .mgr_rdata_i(mgr_rdata), .mgr_err_i(mgr_err)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = '0;
        mgr_gnt = 1'b0;
        man_v   = 1'b0;
        man_d   = '0;
        man_e   = 1'b0;
        auto_en = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    // Downstream model: one-cycle response echoing address ^ K.
    initial begin
        logic          h;
        logic [AW-1:0] a;
        auto_v = 1'b0;
        auto_d = '0;
        forever begin
            @(negedge clk);
            h = mgr_req && mgr_gnt;
            a = mgr_addr;
            @(posedge clk);
            #1;
            auto_v = auto_en && h;
            auto_d = a ^ K;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                if (rvalid[i]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("rvalid_unexpected%0d", i), 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("rsp_idx", i, mon_e.idx);
                        chk("rsp_data", rdata[i*DW +: DW], mon_e.data);
                        chk("rsp_err", err[i], mon_e.err);
                    end
                end
            end
        end
    end

    initial begin
        addr  = '0;
        we    = '0;
        be    = '1;
        wdata = '0;
        man_v = 1'b0;
        man_d = '0;
        man_e = 1'b0;
        auto_en = 1'b0;
        // Requests present during reset must not leak out.
        req     = 2'b11;
        mgr_gnt = 1'b1;
        @(negedge clk);
        chk("rst_mgr_req", mgr_req, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_cnt", dut.cnt_q, 0);
        do_reset();

        // Single requester, same-cycle grant, response next cycle.
        addr[31:0]  = 32'h0000_0100;
        we[0]       = 1'b1;
        wdata[31:0] = 32'h0000_CAFE;
        req     = 2'b01;
        mgr_gnt = 1'b1;
        exp_q.push_back('{0, 32'h0000_A0A0, 1'b0});
        @(negedge clk);
        chk("single_gnt", gnt, 2'b01);
        chk("single_addr", mgr_addr, 32'h100);
        chk("single_we", mgr_we, 1);
        chk("single_wdata", mgr_wdata, 32'hCAFE);
        cyc();
        req     = 2'b00;
        mgr_gnt = 1'b0;
        man_v   = 1'b1;
        man_d   = 32'h0000_A0A0;
        @(negedge clk);
        chk("idle_req", mgr_req, 0);
        chk("idle_addr", mgr_addr, 0);
        cyc();
        man_v = 1'b0;

        // Fairness with an always-granting, always-responding downstream.
        do_reset();
        we      = '0;
        auto_en = 1'b1;
        addr    = {32'h0000_2000, 32'h0000_1000};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back('{0, 32'h0000_1000 ^ K, 1'b0});
            else            exp_q.push_back('{1, 32'h0000_2000 ^ K, 1'b0});
        end
        req     = 2'b11;
        mgr_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", k), gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
        end
        req     = 2'b00;
        mgr_gnt = 1'b0;
        @(negedge clk);
        cyc();
        auto_en = 1'b0;

        // Lock holds requester 1 despite requester 0 gaining priority.
        do_reset();
        auto_en = 1'b1;
        addr    = {32'h0000_3000, 32'h0000_1111};
        req     = 2'b10;
        mgr_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("lock_addr%0d", k), mgr_addr, 32'h3000);
            cyc();
        end
        req = 2'b11;
        @(negedge clk);
        chk("lock_addr_both", mgr_addr, 32'h3000);
        chk("lock_no_gnt", gnt, 2'b00);
        cyc();
        mgr_gnt = 1'b1;
        exp_q.push_back('{1, 32'h0000_3000 ^ K, 1'b0});
        @(negedge clk);
        chk("lock_gnt", gnt, 2'b10);
        cyc();
        req     = 2'b00;
        mgr_gnt = 1'b0;
        @(negedge clk);
        cyc();
        auto_en = 1'b0;

        // Outstanding limit of two.
        do_reset();
        addr[31:0] = 32'h0000_4000;
        req     = 2'b01;
        mgr_gnt = 1'b1;
        exp_q.push_back('{0, 32'hBEEF_0001, 1'b0});
        exp_q.push_back('{0, 32'hBEEF_0002, 1'b1});
        @(negedge clk);
        chk("lim_gnt0", gnt, 2'b01);
        cyc();
        @(negedge clk);
        chk("lim_gnt1", gnt, 2'b01);
        cyc();
        @(negedge clk);
        chk("lim_full_req", mgr_req, 0);
        chk("lim_full_gnt", gnt, 2'b00);
        cyc();
        man_v = 1'b1;
        man_d = 32'hBEEF_0001;
        @(negedge clk);
        chk("lim_pop_req", mgr_req, 0);
        cyc();
        man_v   = 1'b0;
        mgr_gnt = 1'b0;
        @(negedge clk);
        chk("lim_req_back", mgr_req, 1);
        cyc();
        req   = 2'b00;
        man_v = 1'b1;
        man_d = 32'hBEEF_0002;
        man_e = 1'b1;
        @(negedge clk);
        cyc();
        man_v = 1'b0;
        man_e = 1'b0;

        // Responses return in grant order: index 1 then index 0.
        do_reset();
        addr    = {32'h0000_6100, 32'h0000_6000};
        req     = 2'b10;
        mgr_gnt = 1'b1;
        exp_q.push_back('{1, 32'hAAAA_0001, 1'b0});
        exp_q.push_back('{0, 32'hBBBB_0002, 1'b1});
        @(negedge clk);
        chk("ord_gnt1", gnt, 2'b10);
        chk("ord_addr1", mgr_addr, 32'h6100);
        cyc();
        req = 2'b01;
        @(negedge clk);
        chk("ord_gnt0", gnt, 2'b01);
        cyc();
        req     = 2'b00;
        mgr_gnt = 1'b0;
        man_v   = 1'b1;
        man_d   = 32'hAAAA_0001;
        @(negedge clk);
        chk("ord_rsp_a", rvalid, 2'b10);
        cyc();
        man_d = 32'hBBBB_0002;
        man_e = 1'b1;
        @(negedge clk);
        chk("ord_rsp_b", rvalid, 2'b01);
        cyc();
        man_v = 1'b0;
        man_e = 1'b0;

        // Reset with two outstanding, then a stray response.
        do_reset();
        req     = 2'b01;
        mgr_gnt = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("mid_cnt_before", dut.cnt_q, 2);
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", mgr_req, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_cnt", dut.cnt_q, 0);
        cyc();
        rst_n   = 1'b1;
        req     = 2'b00;
        mgr_gnt = 1'b0;
        man_v   = 1'b1;
        man_d   = 32'h0000_DEAD;
        @(negedge clk);
        chk("stray_rvalid", rvalid, 0);
        cyc();
        man_v = 1'b0;
        @(negedge clk);
        chk("stray_cnt", dut.cnt_q, 0);
        cyc();

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/user_obi_mgr_arb.md
USER_OBI_MGR_ARB -- requirements
Module: user_obi_mgr_arb

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of upstream OBI requesters (2..8).
REQ-002 SHALL have parameter AddrWidth, default 32, address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width; byte-enable width is DataWidth/8.
REQ-004 SHALL have parameter MaxTrans, default 2, maximum outstanding downstream transactions (1..4).
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_i, input, NumReq, per-requester A-channel request.
REQ-008 SHALL have port addr_i, we_i, be_i and wdata_i, input, NumReq x (AddrWidth, 1, DataWidth/8, DataWidth), per-requester A-channel payload.
REQ-009 SHALL have port gnt_o, output, NumReq, per-requester grant.
REQ-010 SHALL have port rvalid_o, rdata_o and err_o, output, NumReq x (1, DataWidth, 1), per-requester R-channel.
REQ-011 SHALL have port mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o and mgr_wdata_o, output, downstream A-channel toward the crossbar.
REQ-012 SHALL have port mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i and mgr_err_i, input, downstream grant and R-channel.

Function
REQ-013 SHALL select one requesting index by round-robin: priority pointer starts at 0, and after each downstream handshake (mgr_req_o and mgr_gnt_i both high) moves to the granted index + 1, wrapping at NumReq.
REQ-014 SHALL lock the selected index while mgr_req_o is high and mgr_gnt_i is low, so the downstream A-channel payload stays stable until grant even if higher-priority requests arrive.
REQ-015 SHALL drive mgr_req_o high only when at least one req_i bit is high and the outstanding count is below MaxTrans; the mux is combinational, with zero added cycles on the A path.
REQ-016 SHALL drive the mgr_addr_o/we/be/wdata payload from the selected requester; when mgr_req_o is low, all of it SHALL be zero.
REQ-017 SHALL assert gnt_o[i] = mgr_gnt_i AND mgr_req_o AND (selected == i); all other gnt_o bits SHALL be 0.
REQ-018 SHALL push the granted index into an ID FIFO of depth MaxTrans on each downstream handshake.
REQ-019 SHALL route mgr_rvalid_i, mgr_rdata_i and mgr_err_i combinationally to the requester at the FIFO head, then pop the FIFO; non-head rvalid_o SHALL be 0 and non-head rdata_o/err_o SHALL be 0.
REQ-020 SHALL, when push and pop occur in the same cycle, leave the count unchanged and keep FIFO order.
REQ-021 SHALL treat the FIFO as full at count == MaxTrans, even if a pop occurs in the same cycle, and SHALL then hold mgr_req_o low (no combinational path from rvalid to req).
REQ-022 SHALL ignore mgr_rvalid_i while the FIFO is empty (protocol error): no rvalid_o, count stays at 0 and does not underflow.
REQ-023 SHALL ignore req_i bits that drop before grant; the lock from REQ-014 then releases on the next cycle.

Reset
REQ-024 SHALL, while rst_ni is low, force priority pointer = 0, lock = 0, FIFO count and pointers = 0, mgr_req_o = 0 and all gnt_o/rvalid_o = 0, asynchronously.
REQ-025 SHALL drop outstanding transactions on reset mid-operation: responses arriving after reset are discarded per REQ-022.

Verification
REQ-026 SHALL cover a single requester: req_i=01 with mgr_gnt_i tied high and one-cycle rvalid -> gnt_o=01 in the same cycle, rvalid_o[0] one cycle later with rdata passed through.
REQ-027 SHALL cover fairness: req_i=11 held continuously with an always-granting downstream -> grants alternate 0,1,0,1 over 4 cycles.
REQ-028 SHALL cover the lock: req_i=10 and mgr_gnt_i low for 3 cycles, then req_i=11 -> mgr_addr_o stays at requester 1's address, and index 1 receives the first grant.
REQ-029 SHALL cover the outstanding limit: MaxTrans=2, responses withheld -> after 2 grants mgr_req_o=0; one rvalid -> mgr_req_o returns high the next cycle.
REQ-030 SHALL cover ordering: grants to index 1 then 0 with rdata A then B -> rvalid_o[1] carries A, then rvalid_o[0] carries B.
REQ-031 SHALL cover reset mid-operation: 2 outstanding, rst_ni pulsed low, then a stray mgr_rvalid_i -> all rvalid_o=0 and count=0.
